alu_wb_stage: RTL and testbench
===============================

Name: alu_wb_stage

Overview:
- Execute-to-writeback stage directly downstream of the 8-bit ALU: captures the ALU result, the flag outputs and the destination-register tag into a two-entry skid buffer.
- Presents writeback data to the register file through a valid/ready handshake.
- Maintains the architectural status register {N,Z,C,V}, applying a per-opcode update mask.
- Its stored C flag drives the ALU's external carry-in, so ADC/SBC/ROR/ROL chain across consecutive operations.

Parameters:
- RADDR_W, 3, destination register address width.
- DATA_W, 8, result width; must match the ALU output width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ALU result and tag are valid this cycle.
- in_ready  out  1  stage can accept; registered, equals NOT skid_full.
- in_y  in  DATA_W  ALU result.
- in_z, in_n, in_c, in_v  in  1 each  ALU zero, negative, carry and overflow flags.
- in_op  in  4  ALU opcode that produced in_y.
- in_rd  in  RADDR_W  destination register.
- in_we  in  1  the result is written to the register file.
- flags_clr  in  1  synchronous clear of the status register.
- out_valid  out  1  writeback entry valid.
- out_ready  in  1  register file consumes the entry.
- wb_data  out  DATA_W  writeback data.
- wb_rd  out  RADDR_W  writeback address.
- wb_we  out  1  equals out_valid AND the entry's we bit.
- flags_q  out  4  status register {N,Z,C,V}.
- cin_out  out  1  equals flags_q C bit; feeds the ALU Ext_cin.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - out_valid=0, wb_data=0, wb_rd=0, wb_we=0.
  - flags_q=4'b0000, cin_out=0.
  - Skid entry empty, so in_ready=1 from the first edge after release.
- Accept: an entry is accepted when in_valid AND in_ready at the rising edge.
- Drain: the main entry drains when out_valid AND out_ready.
- Main register update, per edge:
  - If main is empty or draining, it loads from the skid entry if the skid is full, otherwise from the input if accepting.
  - If main is full, not draining and an input is accepted, the input goes to the skid entry.
- Ordering: strictly FIFO; the skid entry always precedes a concurrently accepted input.
- Latency: one cycle from accept to out_valid when the stage is empty; full throughput with out_ready held high.
- Full condition: with main and skid both full, in_ready=0 on the next cycle. in_ready returns to 1 the cycle after the skid drains into main.
- Status register: updated at accept time, not at drain, so a dependent ADC sees the new carry the next cycle. Update mask by in_op:
  - 0000-0011 (ADD, ADC, SUB, SBC): N,Z,C,V all updated.
  - 0100-0111 (AND, OR, XOR, NOT): N,Z updated; C,V hold.
  - 1000, 1001, 1010, 1100, 1101 (shifts and rotates): N,Z,C updated; V holds.
  - 1110, 1111 (PSA, PSB): N,Z updated.
  - 1011 (unused): no flag changes; the entry still passes through to writeback.
- flags_clr:
  - Forces flags_q to 0000 at the edge.
  - Has priority over a same-cycle accept's flag update.
  - Does not affect the data path.
- in_we=0 entries still occupy the buffer and assert out_valid; wb_we stays 0 for them.
- in_valid while in_ready=0: ignored; no flag update.
- Reset mid-operation: both entries are discarded and flags cleared; no partial writeback is emitted.

Optional Feature:
- Macro: ALU_WB_STICKY_V_EN.
- Defined: V is sticky. An accepted update writing V=1 sets it; updates writing V=0 do not clear it. Only flags_clr or reset clears V.
- Undefined: V follows the update mask exactly as above.

Test Plan:
- Reset release, out_ready=1, accept in_y=8'h00, in_op=0000, in_z=1, in_c=1, in_we=1, in_rd=3 -> next cycle out_valid=1, wb_data=00, wb_rd=3, wb_we=1, flags_q=0110, cin_out=1.
- Hold out_ready=0; present three back-to-back entries A1, A2, A3 -> A1 and A2 accepted, in_ready=0 from the cycle after A2, A3 stalls. Raise out_ready -> output order A1, A2, A3 with no loss or duplication.
- After flags_q=0110, accept in_op=0100 (AND), y=8'h80, n=1, c=0 -> flags_q=1010 (C holds at 1, Z cleared, N set).
- flags_clr=1 in the same cycle as accepting in_op=0000 with n=1 -> flags_q=0000; the data entry is still delivered.
- Accept in_op=1011, in_we=0 -> out_valid=1, wb_we=0, flags_q unchanged.
- With the macro defined: ADD with v=1, then ADD with v=0 -> V stays 1 until flags_clr. Without the macro, the same sequence gives V=0.

Source files
------------

// File: rtl/alu_wb_stage.sv
// ============================================================================
// Module  : alu_wb_stage
// Brief   : ALU execute-to-writeback stage: two-entry skid buffer, valid/ready
//           writeback handshake, {N,Z,C,V} status register with per-opcode mask.
//           Optional macro ALU_WB_STICKY_V_EN makes the V flag sticky.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_wb_stage #(
  parameter int RADDR_W = 3,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_y,
  input  logic               in_z,
  input  logic               in_n,
  input  logic               in_c,
  input  logic               in_v,
  input  logic [3:0]         in_op,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_we,
  input  logic               flags_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  wb_data,
  output logic [RADDR_W-1:0] wb_rd,
  output logic               wb_we,
  output logic [3:0]         flags_q,
  output logic               cin_out
);

  logic               main_valid_q, main_valid_d;
  logic [DATA_W-1:0]  main_data_q, main_data_d;
  logic [RADDR_W-1:0] main_rd_q, main_rd_d;
  logic               main_we_q, main_we_d;

  logic               skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0]  skid_data_q, skid_data_d;
  logic [RADDR_W-1:0] skid_rd_q, skid_rd_d;
  logic               skid_we_q, skid_we_d;

  logic [3:0]         flags_d;
  logic               accept;
  logic               drain;
  logic               upd_nz, upd_c, upd_v;
  logic               new_v;

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready;
  assign drain    = main_valid_q & out_ready;

  // Buffer: the skid entry always refills main before a new input can.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_rd_d    = main_rd_q;
    main_we_d    = main_we_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_rd_d    = skid_rd_q;
    skid_we_d    = skid_we_q;
    if (!main_valid_q || drain) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        main_rd_d    = skid_rd_q;
        main_we_d    = skid_we_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = in_y;
        main_rd_d    = in_rd;
        main_we_d    = in_we;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_y;
      skid_rd_d    = in_rd;
      skid_we_d    = in_we;
    end
  end

  always_comb begin
    upd_nz = 1'b1;
    upd_c  = 1'b0;
    upd_v  = 1'b0;
    case (in_op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011: begin
        upd_c = 1'b1;
        upd_v = 1'b1;
      end
      4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1101: upd_c = 1'b1;
      4'b1011: upd_nz = 1'b0;
      default: ;
    endcase
  end

`ifdef ALU_WB_STICKY_V_EN
  assign new_v = flags_q[0] | in_v;
`else
  assign new_v = in_v;
`endif

  // Flags move at accept so a following ADC/SBC sees the fresh carry.
  always_comb begin
    flags_d = flags_q;
    if (flags_clr) begin
      flags_d = 4'b0000;
    end else if (accept) begin
      if (upd_nz) begin
        flags_d[3] = in_n;
        flags_d[2] = in_z;
      end
      if (upd_c) flags_d[1] = in_c;
      if (upd_v) flags_d[0] = new_v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_rd_q    <= '0;
      main_we_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_rd_q    <= '0;
      skid_we_q    <= 1'b0;
      flags_q      <= 4'b0000;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_rd_q    <= main_rd_d;
      main_we_q    <= main_we_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_rd_q    <= skid_rd_d;
      skid_we_q    <= skid_we_d;
      flags_q      <= flags_d;
    end
  end

  assign out_valid = main_valid_q;
  assign wb_data   = main_data_q;
  assign wb_rd     = main_rd_q;
  assign wb_we     = main_valid_q & main_we_q;
  assign cin_out   = flags_q[1];

endmodule

`default_nettype wire

// File: tb/tb_alu_wb_stage.sv
// ============================================================================
// Module  : tb_alu_wb_stage
// Brief   : Scoreboard bench for alu_wb_stage: directed scenarios plus random
//           traffic against a queue/flag reference model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_wb_stage;

  localparam int RADDR_W = 3;
  localparam int DATA_W  = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_y;
  logic               in_z, in_n, in_c, in_v;
  logic [3:0]         in_op;
  logic [RADDR_W-1:0] in_rd;
  logic               in_we;
  logic               flags_clr;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  wb_data;
  logic [RADDR_W-1:0] wb_rd;
  logic               wb_we;
  logic [3:0]         flags_q;
  logic               cin_out;

  alu_wb_stage #(.RADDR_W(RADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_y(in_y), .in_z(in_z), .in_n(in_n), .in_c(in_c), .in_v(in_v),
    .in_op(in_op), .in_rd(in_rd), .in_we(in_we),
    .flags_clr(flags_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we),
    .flags_q(flags_q), .cin_out(cin_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [RADDR_W-1:0] rd;
    logic               we;
  } entry_t;

  entry_t     sb[$];
  logic [3:0] exp_flags;
  logic       last_acc;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference flag rule: which of N,Z,C,V each opcode class rewrites.
  function automatic logic [3:0] model_flags(input logic [3:0] old, input logic [3:0] op,
                                             input logic n, z, c, v);
    logic [3:0] f;
    int o;
    f = old;
    o = int'(op);
    if (o != 11) begin
      f[3] = n;
      f[2] = z;
    end
    if (o <= 3 || o == 8 || o == 9 || o == 10 || o == 12 || o == 13) f[1] = c;
    if (o <= 3) begin
`ifdef ALU_WB_STICKY_V_EN
      f[0] = old[0] | v;
`else
      f[0] = v;
`endif
    end
    return f;
  endfunction

  // Model: a transfer happens when the DUT offers room; room means fewer than two held entries.
  always @(posedge clk) begin
    last_acc = 1'b0;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        last_acc = 1'b1;
        sb.push_back('{data: in_y, rd: in_rd, we: in_we});
      end
      if (flags_clr) exp_flags = 4'b0000;
      else if (last_acc) exp_flags = model_flags(exp_flags, in_op, in_n, in_z, in_c, in_v);
    end
  end

  // Monitor: compares the DUT view against the model away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_wb_data", 32'(wb_data), 32'd0);
      chk("rst_wb_rd", 32'(wb_rd), 32'd0);
      chk("rst_wb_we", 32'(wb_we), 32'd0);
      chk("rst_flags", 32'(flags_q), 32'd0);
    end else begin
      chk("in_ready", 32'(in_ready), 32'(sb.size() < 2));
      chk("out_valid", 32'(out_valid), 32'(sb.size() > 0));
      chk("flags_q", 32'(flags_q), 32'(exp_flags));
      chk("cin_out", 32'(cin_out), 32'(exp_flags[1]));
      if (out_valid && sb.size() > 0) begin
        chk("wb_data", 32'(wb_data), 32'(sb[0].data));
        chk("wb_rd", 32'(wb_rd), 32'(sb[0].rd));
        chk("wb_we", 32'(wb_we), 32'(sb[0].we));
        if (out_ready) void'(sb.pop_front());
      end else begin
        chk("wb_we_idle", 32'(wb_we), 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] y, input logic n, z, c, ov,
                       input logic [3:0] op, input logic [2:0] rd, input logic we,
                       input logic clr);
    in_valid  = v;
    in_y      = y;
    in_n      = n;
    in_z      = z;
    in_c      = c;
    in_v      = ov;
    in_op     = op;
    in_rd     = rd;
    in_we     = we;
    flags_clr = clr;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    flags_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    exp_flags = 4'b0000;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    exp_flags = 4'b0000;
    drive(0, 8'h00, 0, 0, 0, 0, 4'h0, 3'd0, 0, 0);
    #1;
    do_reset();
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_flags", 32'(flags_q), 32'd0);

    // First transaction: one-cycle latency and flag capture
    out_ready = 1'b1;
    drive(1, 8'h00, 0, 1, 1, 0, 4'b0000, 3'd3, 1, 0);
    step();
    idle();
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_wb_data", 32'(wb_data), 32'h00);
    chk("t1_wb_rd", 32'(wb_rd), 32'd3);
    chk("t1_wb_we", 32'(wb_we), 32'd1);
    chk("t1_flags", 32'(flags_q), 32'b0110);
    chk("t1_cin", 32'(cin_out), 32'd1);
    step();

    // Logic op keeps C, rewrites N,Z
    drive(1, 8'h80, 1, 0, 0, 0, 4'b0100, 3'd1, 1, 0);
    step();
    idle();
    chk("and_flags", 32'(flags_q), 32'b1010);
    step();

    // Clear wins over a same-cycle flag update, data still flows
    drive(1, 8'h5A, 1, 0, 1, 1, 4'b0000, 3'd2, 1, 1);
    step();
    idle();
    chk("clr_flags", 32'(flags_q), 32'b0000);
    chk("clr_data", 32'(wb_data), 32'h5A);
    step();

    // Unused opcode: no flag changes, passes through with we=0
    drive(1, 8'h11, 1, 0, 1, 0, 4'b0000, 3'd4, 1, 0);
    step();
    drive(1, 8'h22, 0, 1, 0, 1, 4'b1011, 3'd5, 0, 0);
    step();
    idle();
    chk("op11_valid", 32'(out_valid), 32'd1);
    chk("op11_wb_we", 32'(wb_we), 32'd0);
    chk("op11_flags", 32'(flags_q), 32'b1010);
    step();

    // V behaviour across two ADDs
    drive(1, 8'h01, 0, 0, 0, 1, 4'b0000, 3'd1, 1, 0);
    step();
    drive(1, 8'h02, 0, 0, 0, 0, 4'b0000, 3'd1, 1, 0);
    step();
    idle();
`ifdef ALU_WB_STICKY_V_EN
    chk("v_after_add", 32'(flags_q[0]), 32'd1);
`else
    chk("v_after_add", 32'(flags_q[0]), 32'd0);
`endif
    flags_clr = 1'b1;
    step();
    flags_clr = 1'b0;
    chk("v_after_clr", 32'(flags_q[0]), 32'd0);
    step();

    // Back-pressure: A1, A2 fill the stage, A3 stalls until drained
    out_ready = 1'b0;
    drive(1, 8'hA1, 0, 0, 0, 0, 4'b0101, 3'd1, 1, 0);
    step();
    drive(1, 8'hA2, 0, 0, 0, 0, 4'b0101, 3'd2, 1, 0);
    step();
    chk("full_in_ready", 32'(in_ready), 32'd0);
    drive(1, 8'hA3, 0, 0, 0, 0, 4'b0101, 3'd3, 1, 0);
    step();
    step();
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    begin
      int n;
      n = 0;
      while (!last_acc && n < 20) begin
        step();
        n++;
      end
      chk("a3_accepted", 32'(last_acc), 32'd1);
    end
    idle();
    repeat (4) step();
    chk("a_drained", 32'(sb.size()), 32'd0);

    // Random traffic with one mid-run reset
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 4) != 0, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 4'($urandom), 3'($urandom), 1'($urandom), ($urandom % 16) == 0);
      out_ready = ($urandom % 4) != 0;
      if (i == 300) do_reset();
      step();
    end

    idle();
    out_ready = 1'b1;
    repeat (5) step();
    chk("final_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
